mcdt_arbiter: RTL
=================

// Module: mcdt_arbiter
// PURPOSE
//  Output arbiter for the multi-channel data transfer (mcdt) block. Sits between the per-channel
//  slave FIFOs and the shared mcdt output. Picks one requesting channel, by round-robin or fixed
//  priority, and holds it for a configurable burst of beats. Drives registered data/valid/id out.
// PARAMETERS
//  NCH   3    number of requesting channels (IDW = $clog2(NCH), localparam, min 1)
//  DW    32   data width per channel
//  BLW   4    width of burst length config
// PORTS
//  clk_i        in   1        clock, all logic on rising edge
//  rst_i        in   1        synchronous reset, active-high
//  req_i        in   NCH      chN FIFO non-empty (data available)
//  data_i       in   NCH*DW   chN head-of-FIFO data, slice [N*DW +: DW]
//  ack_o        out  NCH      pop strobe to chN FIFO, one-hot or zero, combinational
//  en_i         in   NCH      channel enable mask, 0 = channel never granted
//  mode_i       in   1        0 = round-robin, 1 = fixed priority (lowest index wins)
//  burst_len_i  in   BLW      beats per grant, 0 treated as 1, sampled at grant
//  out_rdy_i    in   1        downstream can accept mcdt_data_o this cycle
//  mcdt_data_o  out  DW       output data, registered
//  mcdt_val_o   out  1        output data valid, registered
//  mcdt_id_o    out  IDW      source channel of mcdt_data_o, registered
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state=IDLE, grant=0, beat_cnt=0, rr_ptr=NCH-1 so ch0 wins first.
//   mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0. ack_o=0 while rst_i=1.
//   Reset mid-burst abandons the burst. No ack_o is issued in that cycle.
//  elig = req_i & en_i. load_ok = !mcdt_val_o || out_rdy_i.
//  FSM states: IDLE, BURST.
//   IDLE: if elig!=0, pick a winner.
//    - mode 0: first set bit of elig scanning rr_ptr+1, rr_ptr+2, ... with wrap at NCH-1 -> 0.
//    - mode 1: lowest index set in elig.
//    - Then grant<=winner, blen<=max(burst_len_i,1), beat_cnt<=0, go to BURST.
//    - No ack_o in IDLE, so each arbitration costs one bubble cycle. If elig==0, stay in IDLE.
//   BURST: ack_o[grant] = req_i[grant] && en_i[grant] && load_ok.
//    - on ack: beat_cnt++. If beat_cnt==blen-1, go to IDLE and set rr_ptr<=grant.
//    - req_i[grant]==0 or en_i[grant]==0: go to IDLE next cycle and set rr_ptr<=grant.
//      The burst ends early and the unused beats are dropped.
//    - req present but load_ok==0: stall in BURST, no ack, beat_cnt held.
//  Output register:
//   - on ack in cycle N: cycle N+1 shows mcdt_data_o=data_i[grant], mcdt_id_o=grant, mcdt_val_o=1.
//   - no ack and out_rdy_i=1: mcdt_val_o<=0, and data/id hold their last value.
//   - no ack and out_rdy_i=0: all outputs hold (backpressure, data must not change while val=1).
//  Latency from ack to output is 1 cycle. Peak throughput is 1 beat/cycle inside a burst.
//  rr_ptr updates only on burst exit. mode_i and en_i are sampled every cycle.
//  A mode change takes effect at the next IDLE decision.
//  beat_cnt width is BLW. blen max 2^BLW-1 beats, so no wrap inside a burst.
// TESTING
//  T1 reset:
//   - stimulus: rst_i=1 for 3 cycles, req_i=3'b111.
//   - required: ack_o=0, mcdt_val_o=0, mcdt_id_o=0 throughout.
//   - after release: first grant to ch0.
//  T2 round-robin:
//   - stimulus: mode=0, burst_len=2, req=111 held, out_rdy=1.
//   - required id sequence: 0,0,-,1,1,-,2,2,-,0,... with '-' = 1 bubble cycle.
//   - data must match the FIFO order.
//  T3 fixed priority:
//   - stimulus: mode=1, burst_len=1, req=110.
//   - required: only ch1 granted while req[1]=1. When ch1 drains, ch2 is granted.
//  T4 early end:
//   - stimulus: burst_len=4, ch2 has 2 words only.
//   - required: 2 beats id=2, then return to IDLE. Next grant goes to ch0 (rr after 2).
//  T5 backpressure:
//   - stimulus: out_rdy=0 for 5 cycles mid-burst with data 0xDEADBEEF on the output.
//   - required: mcdt_val_o=1 and data stable, ack_o=0.
//   - on resume: exactly one pop per cycle, no beat lost.
//  T6 disable:
//   - stimulus: en_i=011, req=111.
//   - required: ch2 never acked. Clear en_i[0] mid-burst -> IDLE next cycle, then ch1 granted.

Source files
------------

// File: rtl/mcdt_arbiter.sv
// Output arbiter for the mcdt block: grants one requesting channel at a time
// (round-robin or fixed priority), holds it for a burst, and registers the output.
module mcdt_arbiter #(
   parameter  int NCH = 3,
   parameter  int DW  = 32,
   parameter  int BLW = 4,
   localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NCH-1:0]    req_i,
   input  logic [NCH*DW-1:0] data_i,
   output logic [NCH-1:0]    ack_o,
   input  logic [NCH-1:0]    en_i,
   input  logic              mode_i,
   input  logic [BLW-1:0]    burst_len_i,
   input  logic              out_rdy_i,
   output logic [DW-1:0]     mcdt_data_o,
   output logic              mcdt_val_o,
   output logic [IDW-1:0]    mcdt_id_o
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [IDW-1:0]   r_grant;
   logic [IDW-1:0]   r_rrPtr;
   logic [BLW-1:0]   r_blen;
   logic [BLW-1:0]   r_beatCnt;

   logic [NCH-1:0]   w_elig;
   logic             w_loadOk;
   logic [IDW-1:0]   w_winLo;
   logic [IDW-1:0]   w_winHi;
   logic             w_foundHi;
   logic [IDW-1:0]   w_winner;
   logic             w_grantElig;
   logic [DW-1:0]    w_grantData;
   logic             w_ack;
   logic             w_lastBeat;
   logic             w_exit;

   assign w_elig     = req_i & en_i;
   assign w_loadOk   = !mcdt_val_o || out_rdy_i;
   assign w_lastBeat = (r_beatCnt == (r_blen - BLW'(1)));
   assign w_ack      = (r_state == BURST) && w_grantElig && w_loadOk && !rst_i;
   assign w_exit     = (r_state == BURST) && (!w_grantElig || (w_ack && w_lastBeat));

   // Round-robin takes the lowest eligible index above rr_ptr, else wraps to the lowest overall
   always_comb begin
      w_winLo   = '0;
      w_winHi   = '0;
      w_foundHi = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_winLo = IDW'(i);
            if (IDW'(i) > r_rrPtr) begin
               w_winHi   = IDW'(i);
               w_foundHi = 1'b1;
            end
         end
      end
      w_winner = (mode_i || !w_foundHi) ? w_winLo : w_winHi;
   end

   always_comb begin
      w_grantElig = 1'b0;
      w_grantData = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_grant == IDW'(i)) begin
            w_grantElig = w_elig[i];
            w_grantData = data_i[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_elig != '0) w_nextState = BURST;
         BURST:   if (w_exit) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      ack_o = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_ack && (r_grant == IDW'(i))) ack_o[i] = 1'b1;
      end
   end

   // Burst bookkeeping and the output register; data/id hold whenever no new beat lands
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_grant     <= '0;
         r_blen      <= BLW'(1);
         r_beatCnt   <= '0;
         r_rrPtr     <= IDW'(NCH - 1);
         mcdt_data_o <= '0;
         mcdt_val_o  <= 1'b0;
         mcdt_id_o   <= '0;
      end else begin
         if ((r_state == IDLE) && (w_elig != '0)) begin
            r_grant   <= w_winner;
            r_blen    <= (burst_len_i == '0) ? BLW'(1) : burst_len_i;
            r_beatCnt <= '0;
         end
         if (w_ack) begin
            r_beatCnt <= r_beatCnt + BLW'(1);
         end
         if (w_exit) begin
            r_rrPtr <= r_grant;
         end
         if (w_ack) begin
            mcdt_data_o <= w_grantData;
            mcdt_id_o   <= r_grant;
            mcdt_val_o  <= 1'b1;
         end else if (out_rdy_i) begin
            mcdt_val_o  <= 1'b0;
         end
      end
   end

endmodule
